// File: rtl/rr_mux.sv
// rr_mux: N-channel registered multiplexer with round-robin or forced-select
// arbitration, a valid/ready output stage and a saturating transfer counter.
module rr_mux #(
    parameter int unsigned SIZE     = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SELW     = 2,
    parameter int unsigned CNTW     = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [CHANNELS*SIZE-1:0]   IN_DATA,
    input  logic [CHANNELS-1:0]        IN_VALID,
    output logic [CHANNELS-1:0]        IN_READY,
    input  logic                       MODE,
    input  logic [SELW-1:0]            SEL,
    output logic [SIZE-1:0]            OUT,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [SELW-1:0]            OUT_CH,
    output logic [CNTW-1:0]            XFER_CNT
);

    logic [SIZE-1:0]          out_q, out_d;
    logic                     out_valid_q, out_valid_d;
    logic [SELW-1:0]          out_ch_q, out_ch_d;
    logic [CNTW-1:0]          cnt_q, cnt_d;
    logic [SELW-1:0]          last_q, last_d;

    logic                     grant_vld;
    logic [SELW-1:0]          grant_idx;
    logic [CHANNELS-1:0]      vld_shift;
    int unsigned              cand;
    logic [CHANNELS*SIZE-1:0] data_shift;
    logic [SIZE-1:0]          data_sel;
    logic                     load;

    // Valid bits are probed through a shift so the index width never has to
    // match the vector width, which keeps non-power-of-two CHANNELS clean.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        vld_shift = '0;
        cand      = 0;
        if (MODE) begin
            vld_shift = IN_VALID >> SEL;
            if ((32'(SEL) < CHANNELS) && vld_shift[0]) begin
                grant_vld = 1'b1;
                grant_idx = SEL;
            end
        end else begin
            for (int unsigned k = 1; k <= CHANNELS; k++) begin
                cand      = (32'(last_q) + k) % CHANNELS;
                vld_shift = IN_VALID >> cand;
                if (!grant_vld && vld_shift[0]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(cand);
                end
            end
        end
    end

    always_comb begin
        data_shift = IN_DATA >> (32'(grant_idx) * SIZE);
        data_sel   = data_shift[SIZE-1:0];
        load       = !out_valid_q || OUT_READY;
        IN_READY   = '0;
        if (load && grant_vld) begin
            IN_READY = CHANNELS'(1) << grant_idx;
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        if (out_valid_q && OUT_READY && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (load) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_d    = data_sel;
                out_ch_d = grant_idx;
                last_d   = grant_idx;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            cnt_q       <= '0;
            last_q      <= SELW'(CHANNELS - 1);
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
        end
    end

    assign OUT       = out_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_CH    = out_ch_q;
    assign XFER_CNT  = cnt_q;

endmodule
